// File: rtl/search_arbiter.sv
// Round-robin arbiter sharing one closest-value searcher among NUM_REQ requesters.
// Optional WAIT-state timeout is compiled in with `define SEARCH_ARBITER_TIMEOUT_EN.
module search_arbiter #(
    parameter int WIDTH          = 12,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_val_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_value_out,
    output logic                     resp_timeout_out,
    output logic                     start_search_out,
    output logic [WIDTH-1:0]         search_val_out,
    input  logic [WIDTH-1:0]         closest_value_in,
    input  logic                     closest_value_found_in,
    output logic                     busy_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("search_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, grant_q;
    logic [IDX_W-1:0]   pick_idx, scan_idx;
    logic               pick_valid;
    logic [WIDTH-1:0]   pick_val;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               handshake;
    logic               timeout_hit;

    // Scan from the requester after the last grant, wrapping, and take the first valid one.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!pick_valid && req_valid_in[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        pick_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) pick_val = req_val_in[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: every combinational output gets a default before the conditional, so no latch is inferred.
    always_comb begin
        req_ready_out = '0;
        if (rst_n_in && state_q == IDLE && pick_valid) req_ready_out[pick_idx] = 1'b1;
    end

    assign handshake    = |(req_ready_out & req_valid_in);
    assign grant_onehot = NUM_REQ'(1) << grant_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (closest_value_found_in || timeout_hit) state_d = RESPOND;
            RESPOND: state_d = DRAIN;
            DRAIN:   if (!closest_value_found_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= IDLE;
            last_grant_q     <= IDX_W'(NUM_REQ - 1);
            grant_q          <= '0;
            busy_out         <= 1'b0;
            start_search_out <= 1'b0;
            search_val_out   <= '0;
            resp_valid_out   <= '0;
            resp_value_out   <= '0;
        end else begin
            state_q          <= state_d;
            busy_out         <= (state_d != IDLE);
            start_search_out <= handshake;
            resp_valid_out   <= '0;
            if (handshake) begin
                grant_q        <= pick_idx;
                last_grant_q   <= pick_idx;
                search_val_out <= pick_val;
            end
            if (state_q == WAIT) begin
                if (closest_value_found_in) begin
                    resp_value_out <= closest_value_in;
                    resp_valid_out <= grant_onehot;
                end else if (timeout_hit) begin
                    resp_value_out <= search_val_out;
                    resp_valid_out <= grant_onehot;
                end
            end
        end
    end

`ifdef SEARCH_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Expiry fires in the WAIT cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wait_cnt_q       <= '0;
            resp_timeout_out <= 1'b0;
        end else begin
            resp_timeout_out <= timeout_hit && !closest_value_found_in;
            if (state_q == ISSUE)     wait_cnt_q <= '0;
            else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit      = 1'b0;
    assign resp_timeout_out = 1'b0;
`endif

endmodule

// File: doc/search_arbiter.md
SEARCH_ARBITER -- requirements
Module: search_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 12: sample/frequency word width, matching the searcher.
REQ-002 The module SHALL have parameter NUM_REQ, default 4: number of requesters sharing one searcher; legal range 2..16.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 512: WAIT-state cycle limit, used only when the timeout feature is compiled in.
REQ-004 The module SHALL have port clk_in  input  1: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n_in  input  1: reset, asynchronous and active-low.
REQ-006 The module SHALL have port req_valid_in  input  NUM_REQ: per-requester request valid.
REQ-007 The module SHALL have port req_val_in  input  NUM_REQ*WIDTH: per-requester search value; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The module SHALL have port req_ready_out  output  NUM_REQ: per-requester accept strobe, at most one bit high.
REQ-009 The module SHALL have port resp_valid_out  output  NUM_REQ: one-cycle response strobe to the granted requester.
REQ-010 The module SHALL have port resp_value_out  output  WIDTH: response value, shared by all requesters, valid when any resp_valid_out bit is high.
REQ-011 The module SHALL have port resp_timeout_out  output  1: marks the current response as a timeout response.
REQ-012 The module SHALL have port start_search_out  output  1: one-cycle start pulse to the searcher.
REQ-013 The module SHALL have port search_val_out  output  WIDTH: value to search, held stable from the start pulse until the response.
REQ-014 The module SHALL have port closest_value_in  input  WIDTH: searcher result.
REQ-015 The module SHALL have port closest_value_found_in  input  1: searcher done flag; may stay high for more than one cycle.
REQ-016 The module SHALL have port busy_out  output  1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT, RESPOND and DRAIN; all outputs SHALL be registered except req_ready_out.
REQ-018 In IDLE, the arbiter SHALL grant the first requester with req_valid_in high, scanning round-robin from last_grant+1 modulo NUM_REQ, and SHALL drive req_ready_out combinationally for that requester only.
REQ-019 A handshake (valid and ready both high in IDLE) SHALL latch the grant index, set last_grant to it, latch req_val into search_val_out, and move the FSM to ISSUE.
REQ-020 In ISSUE, start_search_out SHALL be 1 for exactly one cycle, and the FSM SHALL then move to WAIT.
REQ-021 In WAIT, the first cycle with closest_value_found_in high SHALL capture closest_value_in into resp_value_out and move the FSM to RESPOND.
REQ-022 In RESPOND, resp_valid_out[grant] SHALL be high for exactly one cycle; the FSM SHALL then move to DRAIN.
REQ-023 In DRAIN, the FSM SHALL stay while closest_value_found_in is high and SHALL move to IDLE on the first low cycle, so a stale done flag is never captured.
REQ-024 Minimum latency SHALL be: handshake at cycle N, start_search_out at N+1, response strobe one cycle after found is sampled in WAIT.
REQ-025 Requesters SHALL hold valid and value stable until ready; the arbiter performs no checks on this, and a requester dropping valid before grant is simply not granted.
REQ-026 The reset value of last_grant SHALL be NUM_REQ-1, so requester 0 has first priority after reset.
REQ-027 A requester re-requesting continuously SHALL NOT be regranted while any other requester is valid at the IDLE decision.

Reset
REQ-028 When rst_n_in is low, the FSM SHALL go to IDLE immediately, asynchronously, including mid-search.
REQ-029 When rst_n_in is low, every registered output SHALL be 0 (resp_valid_out, resp_value_out, resp_timeout_out, start_search_out, search_val_out, busy_out), and last_grant SHALL be NUM_REQ-1.
REQ-030 req_ready_out SHALL be 0 while rst_n_in is low.
REQ-031 No response SHALL be issued for a search aborted by reset.

Configuration
REQ-032 The timeout feature SHALL be controlled by macro SEARCH_ARBITER_TIMEOUT_EN.
REQ-033 When SEARCH_ARBITER_TIMEOUT_EN is defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-034 When SEARCH_ARBITER_TIMEOUT_EN is defined and the counter reaches TIMEOUT_CYCLES with found low, the FSM SHALL move to RESPOND with resp_value_out = search_val_out and resp_timeout_out = 1 for the strobe cycle.
REQ-035 When SEARCH_ARBITER_TIMEOUT_EN is defined and found and expiry coincide, found SHALL win and resp_timeout_out SHALL be 0.
REQ-036 When SEARCH_ARBITER_TIMEOUT_EN is not defined, there SHALL be no counter, WAIT SHALL be unbounded, and resp_timeout_out SHALL be tied to 0.

Verification
REQ-037 The bench SHALL cover: reset release, req_valid_in=4'b0001 with value 440, searcher model returns 440 after 10 cycles -> start_search_out pulse at N+1, resp_valid_out=4'b0001 and resp_value_out=440 one cycle after found.
REQ-038 The bench SHALL cover: all four requesters valid continuously -> grants in order 0,1,2,3,0 and exactly one resp_valid_out bit per transaction.
REQ-039 The bench SHALL cover: found held high 2 cycles, requester 1 waiting -> next start_search_out only after found falls, and no double response.
REQ-040 The bench SHALL cover: rst_n_in pulsed low in WAIT -> outputs 0 immediately, no resp_valid_out, and next grant goes to requester 0.
REQ-041 The bench SHALL cover, with SEARCH_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16: found never asserted, value 300 -> after 16 WAIT cycles resp_value_out=300 and resp_timeout_out=1.
REQ-042 The bench SHALL cover, without SEARCH_ARBITER_TIMEOUT_EN: found withheld for 1000 cycles -> FSM stays in WAIT and busy_out=1.
